sdac_update_sched: RTL and testbench
====================================

// Module: sdac_update_sched
// PURPOSE
//  Schedules updates to the shared sideboard DAC serial driver (AD56x4-style, one channel per frame).
//  Four requesters post new 16-bit codes asynchronously to the frame rate. The block queues one pending
//  value per channel and picks one channel per driver frame, round-robin among pending channels.
//  When no channel is pending it issues keep-alive refreshes. Sits between the loop outputs and the DAC driver.
// PARAMETERS
//  DW        16    DAC code width
//  REFRESH   64    idle frames before a keep-alive refresh write; 0 disables refresh
//  CW        7     refresh counter width; must hold REFRESH
// PORTS
//  clk        in   1      system clock
//  rst_n      in   1      synchronous reset, active low
//  frame_tick in   1      one-cycle strobe; driver is ready to accept a new frame
//  req        in   4      per-channel update strobe; value_N is captured when req[N]=1
//  value      in   4*DW   channel codes, ch0 in [DW-1:0]
//  ch_en      in   4      channel enable mask; disabled channels are never issued
//  dac_trig   out  1      one-cycle start strobe to the driver
//  dac_addr   out  2      channel address, held stable until the next dac_trig
//  dac_data   out  DW     code, held stable until the next dac_trig
//  pending    out  4      per-channel pending flags
//  ack        out  4      one-cycle strobe; that channel's pending value was issued
//  refresh    out  1      high with dac_trig when the issue is a keep-alive refresh
// BEHAVIOUR
//  Reset (rst_n=0 at posedge): all outputs 0; shadow regs 0; rr pointer 3, so ch0 is served first; refresh counter 0; FSM IDLE.
//  Capture: req[N] -> shadow[N]<=value_N and pending[N]<=1 on the next edge. A later req overwrites the shadow (last value wins).
//  FSM IDLE: on frame_tick, go to SEL when (pending&ch_en)!=0 or a refresh is due; otherwise stay in IDLE.
//  FSM SEL (1 cycle): grant = first enabled pending channel searching rr+1, rr+2, ... mod 4.
//   If none is pending, grant = refresh channel (cycles 0..3 over enabled channels).
//   Register dac_addr, dac_data=shadow[grant], rr<=grant (pending grants only). Go to FIRE.
//  FIRE (1 cycle): dac_trig=1. For a pending grant, clear pending[grant] and pulse ack[grant]. Return to IDLE.
//  Latency: frame_tick at cycle t -> dac_trig at t+2. At most one issue per frame_tick.
//  A frame_tick that arrives outside IDLE is ignored; no backlog is kept.
//  Capture/issue collision: a req[grant] in the SEL or FIRE cycle keeps pending[grant]=1 (set beats clear).
//   The new value is issued on a later frame. dac_data keeps the value latched in SEL.
//  Refresh: counter increments on each frame_tick that issues nothing and clears on any issue.
//   A refresh is due when counter >= REFRESH. A refresh issue sets refresh=1 with dac_trig and pulses no ack.
//  ch_en=0: pending stays set but is not issued; it is issued after re-enable. ch_en=4'b0000 means no issues at all.
//  Reset mid-frame: abort without a dac_trig; pending flags are lost (requesters re-post).
//  Widths: no arithmetic on data; rr and refresh channel wrap mod 4; the refresh counter saturates at 2^CW-1.
// STRUCTURE
//  Shared package sdac_pkg: state enum {IDLE,SEL,FIRE}, NCH=4, default DW.
//  Sub-module rr_arb4: combinational 4-way round-robin priority pick (req, ptr -> grant one-hot, valid).
//  It is used twice: for pending channels and for the refresh rotation.
// TESTING
//  1 Reset, then req[2] with 0x1234 and frame_tick -> dac_trig 2 cycles later, addr=2, data=0x1234, ack[2] with it.
//  2 req[0..3] all at once, then 4 frame_ticks -> issues in order ch0,1,2,3; pending=0 at end; 4 acks.
//  3 req[1] 0xAAAA then 0x5555 before any tick -> one issue only, data=0x5555.
//  4 req[1] in the FIRE cycle of a ch1 issue -> pending[1] stays 1; next frame issues the new value.
//  5 REFRESH=4, no reqs, ch_en=4'b1010 -> after 4 idle ticks, refresh issues alternate addr 1,3, refresh=1, ack=0.
//  6 rst_n low during SEL -> no dac_trig; all outputs 0; after reset a tick with no reqs issues nothing.

Source files
------------

// File: rtl/sdac_pkg.sv
// rtl/sdac_pkg.sv - shared types and helpers for the sideboard DAC update scheduler
package sdac_pkg;

  localparam int NCH    = 4;
  localparam int DW_DEF = 16;

  typedef enum logic [1:0] {
    IDLE,
    SEL,
    FIRE
  } state_t;

  function automatic logic [1:0] oh2idx(input logic [3:0] oh);
    oh2idx = '0;
    for (int i = 0; i < NCH; i++) begin
      if (oh[i]) oh2idx = 2'(i);
    end
  endfunction

endpackage

// File: rtl/rr_arb4.sv
// rtl/rr_arb4.sv - combinational 4-way round-robin pick, searching ptr+1, ptr+2, ... mod 4
module rr_arb4 (
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  output logic [3:0] grant,
  output logic       valid
);

  logic [1:0] idx;

  always_comb begin
    grant = '0;
    valid = 1'b0;
    idx   = ptr;
    for (int i = 1; i < 5; i++) begin
      idx = ptr + 2'(i);
      if (!valid && req[idx]) begin
        grant[idx] = 1'b1;
        valid      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sdac_update_sched.sv
// rtl/sdac_update_sched.sv - one DAC channel update per driver frame, round-robin over pending
// channels, with keep-alive refresh writes when the loop outputs go quiet.
module sdac_update_sched
  import sdac_pkg::*;
#(
  parameter int DW      = DW_DEF,
  parameter int REFRESH = 64,
  parameter int CW      = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              frame_tick,
  input  logic [NCH-1:0]    req,
  input  logic [NCH*DW-1:0] value,
  input  logic [NCH-1:0]    ch_en,
  output logic              dac_trig,
  output logic [1:0]        dac_addr,
  output logic [DW-1:0]     dac_data,
  output logic [NCH-1:0]    pending,
  output logic [NCH-1:0]    ack,
  output logic              refresh
);

  localparam bit          REF_EN = (REFRESH != 0);
  localparam logic [CW-1:0] REF_V = CW'(REFRESH);

  state_t        state;
  logic [DW-1:0] shadow [NCH];
  logic [1:0]    rr;
  logic [1:0]    ref_ptr;
  logic [1:0]    gnt;
  logic          is_ref;
  logic          repost;
  logic [CW-1:0] cnt;

  logic [3:0] pend_gnt, ref_gnt;
  logic       pend_v, ref_v, ref_due;
  logic [1:0] pend_idx, ref_idx;

  rr_arb4 u_pend_arb (
    .req  (pending & ch_en),
    .ptr  (rr),
    .grant(pend_gnt),
    .valid(pend_v)
  );

  rr_arb4 u_ref_arb (
    .req  (ch_en),
    .ptr  (ref_ptr),
    .grant(ref_gnt),
    .valid(ref_v)
  );

  assign pend_idx = oh2idx(pend_gnt);
  assign ref_idx  = oh2idx(ref_gnt);
  assign ref_due  = REF_EN && (cnt >= REF_V) && ref_v;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      rr       <= 2'd3;
      ref_ptr  <= 2'd3;
      gnt      <= '0;
      is_ref   <= 1'b0;
      repost   <= 1'b0;
      cnt      <= '0;
      pending  <= '0;
      dac_trig <= 1'b0;
      dac_addr <= '0;
      dac_data <= '0;
      ack      <= '0;
      refresh  <= 1'b0;
      for (int ch = 0; ch < NCH; ch++) shadow[ch] <= '0;
    end else begin
      for (int ch = 0; ch < NCH; ch++) begin
        if (req[ch]) shadow[ch] <= value[ch*DW +: DW];
      end
      pending  <= pending | req;
      dac_trig <= 1'b0;
      ack      <= '0;
      refresh  <= 1'b0;

      case (state)
        IDLE: begin
          if (frame_tick) begin
            if (pend_v || ref_due) state <= SEL;
            else if (cnt != {CW{1'b1}}) cnt <= cnt + 1'b1;
          end
        end
        SEL: begin
          state <= FIRE;
          if (pend_v) begin
            gnt      <= pend_idx;
            rr       <= pend_idx;
            is_ref   <= 1'b0;
            // a re-post landing this cycle must survive the clear in FIRE
            repost   <= |(req & pend_gnt);
            dac_addr <= pend_idx;
            dac_data <= shadow[pend_idx];
            dac_trig <= 1'b1;
            ack      <= pend_gnt;
            cnt      <= '0;
          end else if (ref_due) begin
            gnt      <= ref_idx;
            ref_ptr  <= ref_idx;
            is_ref   <= 1'b1;
            repost   <= 1'b0;
            dac_addr <= ref_idx;
            dac_data <= shadow[ref_idx];
            dac_trig <= 1'b1;
            refresh  <= 1'b1;
            cnt      <= '0;
          end else begin
            state <= IDLE;
          end
        end
        FIRE: begin
          state <= IDLE;
          if (!is_ref) pending[gnt] <= req[gnt] | repost;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sdac_update_sched.sv
// tb/tb_sdac_update_sched.sv - scoreboard bench for sdac_update_sched with directed vectors
module tb_sdac_update_sched;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        frame_tick;
  logic [3:0]  req;
  logic [63:0] value;
  logic [3:0]  ch_en;
  logic        dac_trig;
  logic [1:0]  dac_addr;
  logic [15:0] dac_data;
  logic [3:0]  pending;
  logic [3:0]  ack;
  logic        refresh;

  always #5 clk = ~clk;

  sdac_update_sched #(.DW(16), .REFRESH(4), .CW(7)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .frame_tick(frame_tick),
    .req       (req),
    .value     (value),
    .ch_en     (ch_en),
    .dac_trig  (dac_trig),
    .dac_addr  (dac_addr),
    .dac_data  (dac_data),
    .pending   (pending),
    .ack       (ack),
    .refresh   (refresh)
  );

  typedef struct packed {
    logic [1:0]  addr;
    logic [15:0] data;
    logic [3:0]  ack;
    logic        refresh;
    logic [31:0] cyc;
  } exp_t;

  exp_t        q[$];
  exp_t        mon_e;
  exp_t        mon_g;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] cyc = 0;
  logic [15:0] sh[4];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n && dac_trig) begin
      checks++;
      mon_g = '{addr: dac_addr, data: dac_data, ack: ack, refresh: refresh, cyc: cyc};
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_issue: got addr=%0d data=%h ack=%b refresh=%b cyc=%0d want no issue",
                 dac_addr, dac_data, ack, refresh, cyc);
      end else begin
        mon_e = q.pop_front();
        if (mon_g !== mon_e) begin
          errors++;
          $display("FAIL issue: got addr=%0d data=%h ack=%b refresh=%b cyc=%0d want addr=%0d data=%h ack=%b refresh=%b cyc=%0d",
                   mon_g.addr, mon_g.data, mon_g.ack, mon_g.refresh, mon_g.cyc,
                   mon_e.addr, mon_e.data, mon_e.ack, mon_e.refresh, mon_e.cyc);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic post(input int ch, input logic [15:0] v);
    step();
    req[ch] = 1'b1;
    value[ch*16 +: 16] = v;
    sh[ch] = v;
    step();
    req = '0;
  endtask

  task automatic tick(input bit issue, input logic [1:0] a, input logic [3:0] ak, input bit rf);
    exp_t e;
    step();
    frame_tick = 1'b1;
    if (issue) begin
      e.addr = a;
      e.data = sh[a];
      e.ack = ak;
      e.refresh = rf;
      e.cyc = cyc + 2;
      q.push_back(e);
    end
    step();
    frame_tick = 1'b0;
    idle(3);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle(2);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) sh[i] = '0;
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    exp_t e;
    rst_n = 1'b0;
    frame_tick = 1'b0;
    req = '0;
    value = '0;
    ch_en = 4'hF;
    for (int i = 0; i < 4; i++) sh[i] = '0;
    idle(2);
    check("reset_outputs", 32'({dac_trig, dac_addr, dac_data, pending, ack, refresh}), 32'h0);
    rst_n = 1'b1;
    idle(1);

    // single request on ch2
    post(2, 16'h1234);
    check("t1_pending_set", 32'(pending), 32'h4);
    tick(1'b1, 2'd2, 4'b0100, 1'b0);
    check("t1_pending_clr", 32'(pending), 32'h0);

    // all four at once, served ch0..3 from a fresh pointer
    do_reset();
    step();
    req = 4'hF;
    value = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
    sh[0] = 16'h1111; sh[1] = 16'h2222; sh[2] = 16'h3333; sh[3] = 16'h4444;
    step();
    req = '0;
    check("t2_pending_all", 32'(pending), 32'hF);
    for (int i = 0; i < 4; i++) tick(1'b1, 2'(i), 4'(1 << i), 1'b0);
    check("t2_pending_clr", 32'(pending), 32'h0);

    // last value wins, only one issue
    post(1, 16'hAAAA);
    post(1, 16'h5555);
    tick(1'b1, 2'd1, 4'b0010, 1'b0);
    tick(1'b0, 2'd0, 4'b0000, 1'b0);

    // re-post during the FIRE cycle survives the clear
    post(1, 16'h1111);
    step();
    frame_tick = 1'b1;
    e.addr = 2'd1; e.data = sh[1]; e.ack = 4'b0010; e.refresh = 1'b0; e.cyc = cyc + 2;
    q.push_back(e);
    step();
    frame_tick = 1'b0;
    step();
    req[1] = 1'b1;
    value[31:16] = 16'h2222;
    sh[1] = 16'h2222;
    step();
    req = '0;
    check("t4_pending_kept", 32'(pending), 32'h2);
    idle(2);
    tick(1'b1, 2'd1, 4'b0010, 1'b0);
    check("t4_pending_clr", 32'(pending), 32'h0);

    // keep-alive refresh over channels 1 and 3
    ch_en = 4'b1010;
    for (int r = 0; r < 3; r++) begin
      repeat (4) tick(1'b0, 2'd0, 4'b0000, 1'b0);
      tick(1'b1, (r == 1) ? 2'd3 : 2'd1, 4'b0000, 1'b1);
    end

    // disabled channel keeps its pending flag, issued after re-enable
    ch_en = 4'b0000;
    post(0, 16'hBEEF);
    repeat (5) tick(1'b0, 2'd0, 4'b0000, 1'b0);
    check("t7_pending_held", 32'(pending), 32'h1);
    ch_en = 4'hF;
    tick(1'b1, 2'd0, 4'b0001, 1'b0);
    check("t7_pending_clr", 32'(pending), 32'h0);

    // reset during SEL aborts the frame
    post(2, 16'h7777);
    step();
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    rst_n = 1'b0;
    step();
    check("t6_reset_outputs", 32'({dac_trig, dac_addr, dac_data, pending, ack, refresh}), 32'h0);
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) sh[i] = '0;
    idle(2);
    tick(1'b0, 2'd0, 4'b0000, 1'b0);
    idle(3);
    check("t6_pending_after", 32'(pending), 32'h0);
    check("queue_drained", 32'(q.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
